// File: rtl/program_sequencer_core_pkg.sv
// program_sequencer_core_pkg: shared CPU widths and the program counter reset value
package program_sequencer_core_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int JADDR_W_DEF = 4;
  localparam logic PC_RST_BIT = 1'b1;
endpackage

// File: rtl/program_sequencer_core.sv
// program_sequencer_core: next program memory address mux plus registered program counter
module program_sequencer_core
  import program_sequencer_core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int JADDR_W = JADDR_W_DEF
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic              dont_jmp,
  input  logic [JADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [ADDR_W-1:0]  pc
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target;
  logic              w_take;
  // Reset forces address 0 so the held all-ones pc wraps cleanly into it on release
  always_comb begin
    w_target = {jmp_addr, {(ADDR_W-JADDR_W){1'b0}}};
    w_take   = jmp | (jmp_nz & ~dont_jmp);
    pm_addr  = !sync_reset_n ? '0 : w_take ? w_target : r_pc + 1'b1;
  end
  // pc remembers the address issued this cycle
  always_ff @(posedge clk or negedge sync_reset_n)
    if (!sync_reset_n) r_pc <= {ADDR_W{PC_RST_BIT}};
    else r_pc <= pm_addr;
  assign pc = r_pc;
endmodule

// File: tb/tb_program_sequencer_core.sv
// tb_program_sequencer_core: vector table, corner sequences and random run against a reference model
module tb_program_sequencer_core;
  logic       clk = 1'b0;
  logic       sync_reset_n = 1'b0;
  logic       jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0;
  logic [3:0] jmp_addr = 4'h0;
  logic [7:0] pm_addr, pc;
  int total = 0, bad = 0;
  logic [7:0] mpc;

  program_sequencer_core dut (
    .clk(clk), .sync_reset_n(sync_reset_n), .jmp(jmp), .jmp_nz(jmp_nz),
    .dont_jmp(dont_jmp), .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, j, jn, d;
    logic [3:0] a;
    logic [7:0] epm, epc;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic j, input logic jn, input logic d,
                     input logic [3:0] a, input logic [7:0] epm, input logic [7:0] epc,
                     input string nm);
    sync_reset_n = r; jmp = j; jmp_nz = jn; dont_jmp = d; jmp_addr = a;
    @(negedge clk);
    chk({nm, " pm_addr"}, pm_addr, epm);
    chk({nm, " pc"}, pc, epc);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hFF};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hFF};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 8'hA0, 8'h01};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 8'hA1, 8'hA0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h10, 8'hA1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 8'h11, 8'h10};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 8'h12, 8'h11};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 8'h13, 8'h12};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 8'h14, 8'h13};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 8'h15, 8'h14};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 8'h50, 8'h15};
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++)
      cyc(tbl[i].r, tbl[i].j, tbl[i].jn, tbl[i].d, tbl[i].a, tbl[i].epm, tbl[i].epc,
          $sformatf("vec%0d", i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'hF0, 8'h50, "jump_f0");
    for (int i = 1; i <= 14; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'(8'hF0 + i), 8'(8'hF0 + i - 1), "run_to_fe");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'hFF, 8'hFE, "seq_ff");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hFF, "wrap_00");
    jmp = 1'b1; jmp_addr = 4'h7;
    #1;
    chk("prejump pm_addr", pm_addr, 8'h70);
    chk("prejump pc", pc, 8'h00);
    sync_reset_n = 1'b0;
    #1;
    chk("async rst pm_addr", pm_addr, 8'h00);
    chk("async rst pc", pc, 8'hFF);
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 8'h00, 8'hFF, "held rst");
    mpc = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      logic r, j, jn, d;
      logic [3:0] a;
      logic [7:0] epm, epc;
      r  = ($urandom % 16) != 0;
      j  = ($urandom % 4) == 0;
      jn = $urandom % 2 == 1;
      d  = $urandom % 2 == 1;
      a  = 4'($urandom);
      epc = r ? mpc : 8'hFF;
      epm = !r ? 8'h00 : (j || (jn && !d)) ? {a, 4'h0} : 8'(mpc + 8'd1);
      cyc(r, j, jn, d, a, epm, epc, "rand");
      mpc = r ? epm : 8'hFF;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
